// File: rtl/prbs11_pkg.sv
// Shared constants, state encoding and tap helper for the PRBS-11 (x^11 + x^9 + 1) link.
package prbs11_pkg;
    localparam int PRBS_LEN = 11;
    localparam int TAP_A    = 9;
    localparam int TAP_B    = 11;

    // Generator seed; benches build reference streams from it
    localparam logic [PRBS_LEN-1:0] PRBS_SEED = 11'h7FF;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic logic prbs_predict(input logic [PRBS_LEN:1] h);
        return h[TAP_A] ^ h[TAP_B];
    endfunction
endpackage

// File: rtl/prbs11_if.sv
// Serial receive stream plus link-quality status of the PRBS-11 checker.
interface prbs11_if #(
    parameter int ERR_W = 16
);
    logic             in_bit;
    logic             in_valid;
    logic             err_clr;
    logic             locked;
    logic             error;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_bit, in_valid, err_clr,
        input  locked, error, err_count
    );

    modport slave (
        input  in_bit, in_valid, err_clr,
        output locked, error, err_count
    );
endinterface

// File: rtl/prbs11_err_window.sv
// Loss-of-lock window: counts errors over WINDOW beats and flags when LOSS_THRESH is reached.
module prbs11_err_window #(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic beat,
    input  logic err,
    input  logic start,
    output logic loss
);
    localparam int CNT_W  = $clog2(WINDOW);
    localparam int ERRC_W = $clog2(WINDOW + 1);

    logic [CNT_W-1:0]  win_q, win_d;
    logic [ERRC_W-1:0] werr_q, werr_d;
    logic [ERRC_W-1:0] werr_now;

    always_comb begin
        // The current beat's error counts toward the window it lands in, wrap beat included
        werr_now = werr_q + ERRC_W'(err);
        loss     = beat && (werr_now >= ERRC_W'(LOSS_THRESH));
        win_d    = win_q;
        werr_d   = werr_q;
        if (start) begin
            win_d  = '0;
            werr_d = '0;
        end else if (beat) begin
            if (win_q == CNT_W'(WINDOW - 1)) begin
                win_d  = '0;
                werr_d = '0;
            end else begin
                win_d  = win_q + 1'b1;
                werr_d = werr_now;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            win_q  <= '0;
            werr_q <= '0;
        end else begin
            win_q  <= win_d;
            werr_q <= werr_d;
        end
    end
endmodule

// File: rtl/prbs11_checker.sv
// Self-synchronizing PRBS-11 receiver: acquires lock, then counts bit errors against its own prediction.
module prbs11_checker
    import prbs11_pkg::*;
#(
    parameter int LOCK_COUNT  = 22,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic     clock,
    input  logic     clear,
    prbs11_if.slave  bus
);
    state_e            state_q, state_d;
    logic [PRBS_LEN:1] hist_q, hist_d;
    logic [3:0]        fill_q, fill_d;
    logic [7:0]        cons_q, cons_d;
    logic              error_q, error_d;
    logic [ERR_W-1:0]  errc_q, errc_d;

    logic p;
    logic mismatch;
    logic win_beat;
    logic win_start;
    logic loss;

    assign p        = prbs_predict(hist_q);
    assign mismatch = bus.in_bit != p;
    assign win_beat = bus.in_valid && (state_q == LOCKED);

    prbs11_err_window #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_window (
        .clock (clock),
        .clear (clear),
        .beat  (win_beat),
        .err   (mismatch),
        .start (win_start),
        .loss  (loss)
    );

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cons_d    = cons_q;
        errc_d    = errc_q;
        error_d   = 1'b0;
        win_start = 1'b0;
        if (bus.in_valid) begin
            if (fill_q != 4'(PRBS_LEN)) fill_d = fill_q + 1'b1;
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[PRBS_LEN-1:1], bus.in_bit};
                    // A zero history predicts zero forever, so it never counts as a match
                    if (fill_q == 4'(PRBS_LEN) && hist_q != '0 && !mismatch) begin
                        cons_d = cons_q + 1'b1;
                        if (cons_q == 8'(LOCK_COUNT - 1)) begin
                            state_d   = LOCKED;
                            win_start = 1'b1;
                        end
                    end else begin
                        cons_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a flipped bit is charged only once
                    hist_d = {hist_q[PRBS_LEN-1:1], p};
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (errc_q != '1) errc_d = errc_q + 1'b1;
                    end
                    if (loss) begin
                        state_d = SEARCH;
                        cons_d  = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        if (bus.err_clr) errc_d = '0;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            fill_q  <= '0;
            cons_q  <= '0;
            error_q <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cons_q  <= cons_d;
            error_q <= error_d;
            errc_q  <= errc_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.error     = error_q;
    assign bus.err_count = errc_q;
endmodule

// File: doc/prbs11_checker.md
# prbs11_checker

Serial PRBS-11 receiver/checker for the 11-bit Fibonacci LFSR generator (polynomial x^11 + x^9 + 1, recurrence s[n] = s[n-9] ^ s[n-11]). It self-synchronizes to an incoming one-bit stream, declares lock, and then counts bit errors against its own locally predicted sequence. If the error density gets too high, it drops lock and re-acquires. It sits at the far end of the serial link, opposite the generator, and feeds link-quality status to the test harness.

## Interface
- LOCK_COUNT, 22: consecutive correct predictions required to declare lock (range 1..255).
- WINDOW, 64: length, in valid beats, of the loss-of-lock observation window (power of two, 8..1024).
- LOSS_THRESH, 4: errors within one window that force loss of lock (1..WINDOW).
- ERR_W, 16: width of the error counter.
- clock  in  1  sole clock; all state changes on its rising edge.
- clear  in  1  asynchronous, active-low reset; returns all state to reset values immediately.
- in_bit  in  1  received serial bit; sampled only when in_valid=1.
- in_valid  in  1  qualifies in_bit; one bit per clock at most.
- err_clr  in  1  synchronous clear of err_count; the window state is not affected.
- locked  out  1  high while in state LOCKED; reset value 0.
- error  out  1  one-cycle pulse per mismatched bit while LOCKED; reset value 0.
- err_count  out  ERR_W  saturating count of mismatches while LOCKED; reset value 0.

## Operation
- History register hist[11:1]: hist[k] is the bit from k valid beats ago. Prediction p = hist[9] ^ hist[11]. Reset value of hist is 0.
- fill counter 0..11 counts valid beats after reset. There are no comparisons until fill=11. fill saturates and is never reloaded except by reset.
- States (shared package enum): SEARCH (reset state) and LOCKED.
- SEARCH, per valid beat:
  - Shift in in_bit.
  - If fill=11, hist≠0 and in_bit==p: increment the consecutive counter.
  - Otherwise: set the consecutive counter to 0.
  - When the counter reaches LOCK_COUNT: go to LOCKED, clear the window counter and the window error count.
  - The all-zero guard means an all-zero stream never locks.
- LOCKED, per valid beat:
  - Shift in p, not in_bit, so one flipped bit costs exactly one error.
  - If in_bit≠p: pulse error and increment err_count, saturating at 2^ERR_W-1.
  - The window counter wraps at WINDOW-1; at the wrap, the window error count is zeroed.
  - If the window error count (including the current beat) reaches LOSS_THRESH: go to SEARCH and set the consecutive counter to 0.
  - The mismatch that triggers loss is still counted and still pulses error.
- Simultaneous events:
  - err_clr together with a counted error: err_count becomes 0, clear wins.
  - Error on the wrap beat: counts toward the window that is ending, then the window resets.
- in_valid=0: no state changes, and error stays 0.
- Reset mid-stream: asynchronous return to SEARCH with fill=0. Re-acquisition needs a fresh 11 + LOCK_COUNT valid beats.

## Timing
- All outputs are registered and change only on clock edges (or asynchronously to reset values on clear).
- error and the err_count update appear in the cycle after the mismatching valid beat.
- locked rises in the cycle after the LOCK_COUNT-th consecutive correct beat. It falls in the cycle after the beat that reaches LOSS_THRESH.
- Minimum acquisition time with continuous in_valid: 11 + LOCK_COUNT beats.
- Throughput: one bit per clock. No back-pressure.

## Structure
- Shared package prbs11_pkg holds:
  - PRBS_LEN=11 and the tap positions TAP_A=9, TAP_B=11.
  - The state enum {SEARCH, LOCKED}.
  - The generator seed constant 11'h7FF, so benches can build reference streams.
- Optional sub-module prbs11_err_window: window counter plus window error count, with inputs beat, err, start and output loss.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- Acquisition: clear low then high, generator seeded 11'h7FF on in_bit with in_valid=1 continuously (first 11 bits are 1, bit 11 is 0) → locked rises in the cycle after the 33rd valid beat; error never pulses; err_count=0.
- Single flip: after lock, invert one bit → exactly one error pulse, the cycle after that beat; err_count=1; locked stays 1; later bits cause no errors.
- Loss of lock: after lock, invert 4 bits within 64 beats → 4 error pulses, err_count=4, locked falls after the 4th; continuing with a clean stream → relock after 22 further correct beats (hist is already full).
- Sparse errors: 3 flips per 64-beat window, repeated across 10 windows → locked stays 1; err_count=30.
- All-zero / gaps: in_bit=0 for 200 beats → locked never rises. A locked stream with random in_valid gaps → no errors, and locked is held.
- Resets and saturation: clear pulsed mid-lock → locked=0, error=0, err_count=0 immediately. With ERR_W=4, 20 errors → err_count holds at 15. err_clr on the same cycle as an error → err_count=0.
